// File: rtl/blk_31fce7_pkg.sv
// Shared constants, types and helpers for the AXI write splitter.
package blk_31fce7_pkg;

  localparam int BOUNDARY_4K = 4096;
  localparam int AXI_MAX_LEN = 256;

  typedef enum logic {
    IDLE  = 1'b0,
    SPLIT = 1'b1
  } split_state_t;

  // Ceiling log2, used for widths and byte-lane shifts.
  function automatic int log2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < value) r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/blk_31fce7_fifo.sv
// Small synchronous FIFO carrying burst lengths from the AW side to the W side.
module weight_s_loader_wq_weight_s_sum_mmap_m_axi_fifo
  import blk_31fce7_pkg::*;
#(
  parameter int DATA_WIDTH = 9,
  parameter int DEPTH      = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  clk_en,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] pop_data,
  output logic                  full,
  output logic                  empty
);

  localparam int PTR_W = (DEPTH > 1) ? log2(DEPTH) : 1;
  localparam int CNT_W = log2(DEPTH + 1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      rd_ptr;
  logic [PTR_W-1:0]      wr_ptr;
  logic [CNT_W-1:0]      count;
  logic                  do_push;
  logic                  do_pop;

  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = clk_en & push & ~full;
  assign do_pop   = clk_en & pop & ~empty;
  assign pop_data = mem[rd_ptr];

  // Storage array: written on push, never reset since occupancy gates reads.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointer and occupancy tracking; push and pop together leave count unchanged.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/blk_31fce7.sv
// AXI write splitter: breaks a long write request into bursts that respect
// MAX_BURST and 4 KB boundaries, and frames the user W stream with WLAST.
module blk_31fce7
  import blk_31fce7_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int MAX_BURST      = 16,
  parameter int LEN_FIFO_DEPTH = 8
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    clk_en,
  input  logic [ADDR_WIDTH-1:0]   in_REQ_ADDR,
  input  logic [31:0]             in_REQ_LEN,
  input  logic                    in_REQ_VALID,
  output logic                    out_REQ_READY,
  input  logic [DATA_WIDTH-1:0]   in_USR_WDATA,
  input  logic [DATA_WIDTH/8-1:0] in_USR_WSTRB,
  input  logic                    in_USR_WVALID,
  output logic                    out_USR_WREADY,
  output logic [ADDR_WIDTH-1:0]   out_AWADDR,
  output logic [7:0]              out_AWLEN,
  output logic                    out_AWVALID,
  input  logic                    in_AWREADY,
  output logic [DATA_WIDTH-1:0]   out_WDATA,
  output logic [DATA_WIDTH/8-1:0] out_WSTRB,
  output logic                    out_WLAST,
  output logic                    out_WVALID,
  input  logic                    in_WREADY
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int ALIGN = log2(BYTES);
  localparam int CNT_W = log2(AXI_MAX_LEN) + 1;

  split_state_t          state;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [31:0]           remaining;
  logic [CNT_W-1:0]      burst_beats;
  logic [CNT_W-1:0]      head_beats;
  logic [CNT_W-1:0]      beat_cnt;
  logic                  q_full;
  logic                  q_empty;
  logic                  aw_hs;
  logic                  w_hs;

  // Burst size: the smallest of remaining beats, MAX_BURST and beats to the 4 KB page end.
  always_comb begin
    logic [12:0] page_off;
    logic [12:0] bytes_left;
    logic [12:0] beats_left;
    logic [31:0] cap;
    page_off   = {1'b0, cur_addr[11:0]};
    bytes_left = 13'(BOUNDARY_4K) - page_off;
    beats_left = bytes_left >> ALIGN;
    cap        = (32'(beats_left) < 32'(MAX_BURST)) ? 32'(beats_left) : 32'(MAX_BURST);
    if (remaining < cap) cap = remaining;
    burst_beats = CNT_W'(cap);
  end

  assign out_REQ_READY = (state == IDLE);
  assign out_AWVALID   = (state == SPLIT) & ~q_full;
  assign out_AWADDR    = cur_addr;
  assign out_AWLEN     = 8'(burst_beats - 1'b1);
  assign aw_hs         = out_AWVALID & in_AWREADY;

  // Request acceptance and burst-by-burst address/length walk.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= IDLE;
      cur_addr  <= '0;
      remaining <= '0;
    end else if (clk_en) begin
      case (state)
        IDLE: begin
          if (in_REQ_VALID && in_REQ_LEN != 32'd0) begin
            cur_addr  <= in_REQ_ADDR & ~ADDR_WIDTH'(BYTES - 1);
            remaining <= in_REQ_LEN;
            state     <= SPLIT;
          end
        end
        SPLIT: begin
          if (aw_hs) begin
            cur_addr  <= cur_addr + (ADDR_WIDTH'(burst_beats) << ALIGN);
            remaining <= remaining - 32'(burst_beats);
            if (remaining == 32'(burst_beats)) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  weight_s_loader_wq_weight_s_sum_mmap_m_axi_fifo #(
    .DATA_WIDTH (CNT_W),
    .DEPTH      (LEN_FIFO_DEPTH)
  ) u_len_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .clk_en    (clk_en),
    .push      (aw_hs),
    .push_data (burst_beats),
    .pop       (w_hs & out_WLAST),
    .pop_data  (head_beats),
    .full      (q_full),
    .empty     (q_empty)
  );

  assign out_WDATA      = in_USR_WDATA;
  assign out_WSTRB      = in_USR_WSTRB;
  assign out_WVALID     = in_USR_WVALID & ~q_empty;
  assign out_USR_WREADY = in_WREADY & ~q_empty;
  assign out_WLAST      = ~q_empty & (beat_cnt == head_beats - 1'b1);
  assign w_hs           = out_WVALID & in_WREADY;

  // Beat position within the head burst; wraps to zero when WLAST is accepted.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      beat_cnt <= '0;
    end else if (clk_en && w_hs) begin
      beat_cnt <= out_WLAST ? '0 : beat_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_blk_31fce7.sv
// Directed and randomised checks for the AXI write splitter.
module tb_blk_31fce7;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        clk_en;
  logic [31:0] in_REQ_ADDR;
  logic [31:0] in_REQ_LEN;
  logic        in_REQ_VALID;
  logic        out_REQ_READY;
  logic [31:0] in_USR_WDATA;
  logic [3:0]  in_USR_WSTRB;
  logic        in_USR_WVALID;
  logic        out_USR_WREADY;
  logic [31:0] out_AWADDR;
  logic [7:0]  out_AWLEN;
  logic        out_AWVALID;
  logic        in_AWREADY;
  logic [31:0] out_WDATA;
  logic [3:0]  out_WSTRB;
  logic        out_WLAST;
  logic        out_WVALID;
  logic        in_WREADY;

  always #5 clk = ~clk;

  blk_31fce7 #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_BURST(16), .LEN_FIFO_DEPTH(8)
  ) dut (
    .clk(clk), .reset_n(reset_n), .clk_en(clk_en),
    .in_REQ_ADDR(in_REQ_ADDR), .in_REQ_LEN(in_REQ_LEN), .in_REQ_VALID(in_REQ_VALID),
    .out_REQ_READY(out_REQ_READY),
    .in_USR_WDATA(in_USR_WDATA), .in_USR_WSTRB(in_USR_WSTRB), .in_USR_WVALID(in_USR_WVALID),
    .out_USR_WREADY(out_USR_WREADY),
    .out_AWADDR(out_AWADDR), .out_AWLEN(out_AWLEN), .out_AWVALID(out_AWVALID),
    .in_AWREADY(in_AWREADY),
    .out_WDATA(out_WDATA), .out_WSTRB(out_WSTRB), .out_WLAST(out_WLAST),
    .out_WVALID(out_WVALID), .in_WREADY(in_WREADY)
  );

  typedef struct packed {
    logic [31:0]      addr;
    int               len;
    int               n_aw;
    logic [0:2][31:0] exp_addr;
    logic [0:2][7:0]  exp_len;
  } vec_t;

  vec_t vecs [7];

  int  total = 0;
  int  bad   = 0;
  int  aw_addr_q [$];
  int  aw_len_q  [$];
  int  pend_q    [$];
  int  wlast_pos_q [$];
  int  cur_beats;
  int  beat_total;
  bit  req_seen;
  bit  rand_bp;
  bit  check_4k;

  // Compare one observed value against the bench's expectation.
  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic vec_t make_vec(input logic [31:0] addr, input int len, input int n,
                                    input logic [31:0] a0, input logic [7:0] l0,
                                    input logic [31:0] a1, input logic [7:0] l1,
                                    input logic [31:0] a2, input logic [7:0] l2);
    vec_t v;
    v.addr = addr; v.len = len; v.n_aw = n;
    v.exp_addr = {a0, a1, a2};
    v.exp_len  = {l0, l1, l2};
    return v;
  endfunction

  task automatic clear_model();
    aw_addr_q.delete(); aw_len_q.delete(); pend_q.delete(); wlast_pos_q.delete();
    cur_beats = 0; beat_total = 0;
  endtask

  // One clock: settle inputs, observe the handshakes of the coming edge, then advance.
  task automatic tick();
    if (rand_bp) begin
      in_AWREADY    = ($urandom_range(0, 3) != 0);
      in_WREADY     = ($urandom_range(0, 3) != 0);
      in_USR_WVALID = ($urandom_range(0, 3) != 0);
      in_USR_WDATA  = $urandom;
    end
    #1;
    req_seen = in_REQ_VALID && out_REQ_READY;
    if (out_AWVALID && in_AWREADY) begin
      aw_addr_q.push_back(int'(out_AWADDR));
      aw_len_q.push_back(int'(out_AWLEN));
      pend_q.push_back(int'(out_AWLEN) + 1);
      if (check_4k)
        check("no_4k_cross", longint'(((out_AWADDR & 32'hFFF) + (32'(out_AWLEN) + 1) * 4) <= 32'd4096), 1);
    end
    if (out_WVALID && in_WREADY) begin
      check("w_after_aw", longint'(pend_q.size() > 0), 1);
      if (pend_q.size() > 0) begin
        check("wlast_spacing", out_WLAST, longint'(cur_beats + 1 == pend_q[0]));
        if (cur_beats + 1 == pend_q[0]) begin
          void'(pend_q.pop_front());
          cur_beats = 0;
        end else begin
          cur_beats++;
        end
      end
      beat_total++;
      if (out_WLAST) wlast_pos_q.push_back(beat_total);
    end
    @(negedge clk);
  endtask

  task automatic applyStimulus(input logic [31:0] addr, input int len);
    int n;
    in_REQ_ADDR  = addr;
    in_REQ_LEN   = len;
    in_REQ_VALID = 1'b1;
    n = 0;
    req_seen = 1'b0;
    while (!req_seen && n < 2000) begin
      tick();
      n++;
    end
    in_REQ_VALID = 1'b0;
    check("req_accepted", req_seen, 1);
  endtask

  task automatic wait_beats(input int target, input int budget);
    int n;
    n = 0;
    while (beat_total < target && n < budget) begin
      tick();
      n++;
    end
    check("beats_done", beat_total, target);
  endtask

  task automatic checkOutput(input int idx);
    int cum;
    check("aw_count", aw_addr_q.size(), vecs[idx].n_aw);
    cum = 0;
    for (int j = 0; j < vecs[idx].n_aw; j++) begin
      cum += int'(vecs[idx].exp_len[j]) + 1;
      check("aw_addr", (j < aw_addr_q.size()) ? aw_addr_q[j] : -1, int'(vecs[idx].exp_addr[j]));
      check("aw_len", (j < aw_len_q.size()) ? aw_len_q[j] : -1, int'(vecs[idx].exp_len[j]));
      check("wlast_pos", (j < wlast_pos_q.size()) ? wlast_pos_q[j] : -1, cum);
    end
  endtask

  initial begin
    int n;
    longint sum;
    rand_bp = 1'b0; check_4k = 1'b0;
    reset_n = 1'b0; clk_en = 1'b1;
    in_REQ_ADDR = '0; in_REQ_LEN = '0; in_REQ_VALID = 1'b0;
    in_USR_WDATA = '0; in_USR_WSTRB = 4'hF; in_USR_WVALID = 1'b1;
    in_AWREADY = 1'b1; in_WREADY = 1'b1;
    clear_model();

    vecs[0] = make_vec(32'h0FF0, 20, 2, 32'h0FF0, 8'd3, 32'h1000, 8'd15, 32'h0, 8'd0);
    vecs[1] = make_vec(32'h0000, 40, 3, 32'h0000, 8'd15, 32'h0040, 8'd15, 32'h0080, 8'd7);
    vecs[2] = make_vec(32'h0003, 5, 1, 32'h0000, 8'd4, 32'h0, 8'd0, 32'h0, 8'd0);
    vecs[3] = make_vec(32'h0FFC, 2, 2, 32'h0FFC, 8'd0, 32'h1000, 8'd0, 32'h0, 8'd0);
    vecs[4] = make_vec(32'h1F80, 16, 1, 32'h1F80, 8'd15, 32'h0, 8'd0, 32'h0, 8'd0);
    vecs[5] = make_vec(32'h2FC0, 20, 2, 32'h2FC0, 8'd15, 32'h3000, 8'd3, 32'h0, 8'd0);
    vecs[6] = make_vec(32'h0400, 1, 1, 32'h0400, 8'd0, 32'h0, 8'd0, 32'h0, 8'd0);

    @(negedge clk);
    tick(); tick();
    reset_n = 1'b1;
    #1;
    check("rst_req_ready", out_REQ_READY, 1);
    check("rst_awvalid", out_AWVALID, 0);
    check("rst_wvalid", out_WVALID, 0);
    check("rst_usr_wready", out_USR_WREADY, 0);
    check("rst_wlast", out_WLAST, 0);
    in_USR_WDATA = 32'hA5A5_1234; in_USR_WSTRB = 4'h6;
    #1;
    check("wdata_pass", out_WDATA, 32'hA5A5_1234);
    check("wstrb_pass", out_WSTRB, 4'h6);
    in_USR_WSTRB = 4'hF;
    @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      clear_model();
      applyStimulus(vecs[i].addr, vecs[i].len);
      wait_beats(vecs[i].len, 500);
      checkOutput(i);
    end

    clear_model();
    applyStimulus(32'h0100, 0);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("len0_awvalid", out_AWVALID, 0);
      check("len0_ready", out_REQ_READY, 1);
    end
    check("len0_aw_count", aw_addr_q.size(), 0);

    clear_model();
    in_WREADY = 1'b0;
    applyStimulus(32'h0000, 160);
    for (int i = 0; i < 40; i++) tick();
    check("full_aw_count", aw_addr_q.size(), 8);
    check("full_awvalid", out_AWVALID, 0);
    in_WREADY = 1'b1;
    n = 0;
    while (wlast_pos_q.size() == 0 && n < 100) begin
      tick();
      n++;
    end
    check("first_pop_seen", wlast_pos_q.size(), 1);
    check("full_aw_before_pop", aw_addr_q.size(), 8);
    tick();
    check("aw_after_pop", aw_addr_q.size(), 9);
    wait_beats(160, 1000);
    check("full_aw_total", aw_addr_q.size(), 10);

    clear_model();
    applyStimulus(32'h0000, 40);
    n = 0;
    while ((aw_addr_q.size() < 2 || beat_total < 5) && n < 100) begin
      if (aw_addr_q.size() >= 2) in_AWREADY = 1'b0;
      if (beat_total >= 5) in_WREADY = 1'b0;
      tick();
      n++;
    end
    in_AWREADY = 1'b0; in_WREADY = 1'b0;
    check("pre_rst_aw", aw_addr_q.size(), 2);
    check("pre_rst_beats", beat_total, 5);
    reset_n = 1'b0;
    tick();
    check("midrst_awvalid", out_AWVALID, 0);
    check("midrst_wvalid", out_WVALID, 0);
    check("midrst_ready", out_REQ_READY, 1);
    reset_n = 1'b1;
    clear_model();
    in_AWREADY = 1'b1; in_WREADY = 1'b1;
    applyStimulus(32'h0200, 4);
    wait_beats(4, 100);
    check("post_rst_aw_count", aw_addr_q.size(), 1);
    check("post_rst_awlen", (aw_len_q.size() > 0) ? aw_len_q[0] : -1, 3);
    check("post_rst_wlast", (wlast_pos_q.size() > 0) ? wlast_pos_q[0] : -1, 4);
    check("post_rst_wlast_count", wlast_pos_q.size(), 1);

    clear_model();
    rand_bp = 1'b1; check_4k = 1'b1;
    sum = 0;
    for (int i = 0; i < 1000; i++) begin
      int len;
      len = $urandom_range(1, 24);
      applyStimulus(32'($urandom_range(0, 4095)) * 32'd4, len);
      sum += len;
    end
    wait_beats(int'(sum), 20000);
    rand_bp = 1'b0;
    check("rand_pending_bursts", pend_q.size(), 0);
    check("rand_total_beats", beat_total, sum);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/blk_31fce7.md
WEIGHT_S_LOADER_WQ_WEIGHT_S_SUM_MMAP_M_AXI_WRITE_SPLITTER -- requirements
Module: weight_s_loader_wq_weight_s_sum_mmap_m_axi_write_splitter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, byte-address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, W beat width in bits (power of 2, ≥8).
REQ-003 SHALL have parameter MAX_BURST, default 16, maximum beats per burst (1..256).
REQ-004 SHALL have parameter LEN_FIFO_DEPTH, default 8, burst-length queue depth between AW and W sides.
REQ-005 SHALL use a single clock; reset is synchronous and active-low; ports are named clk and reset_n.
REQ-006 Ports: clk, in, 1, clock; reset_n, in, 1, synchronous active-low reset; clk_en, in, 1, global enable (state holds when low).
REQ-007 Ports: in_REQ_ADDR, in, ADDR_WIDTH, start byte address; in_REQ_LEN, in, 32, total beats; in_REQ_VALID, in, 1; out_REQ_READY, out, 1.
REQ-008 Ports: in_USR_WDATA, in, DATA_WIDTH; in_USR_WSTRB, in, DATA_WIDTH/8; in_USR_WVALID, in, 1; out_USR_WREADY, out, 1.
REQ-009 Ports (toward the throttle stage): out_AWADDR, out, ADDR_WIDTH; out_AWLEN, out, 8; out_AWVALID, out, 1; in_AWREADY, in, 1; out_WDATA, out, DATA_WIDTH; out_WSTRB, out, DATA_WIDTH/8; out_WLAST, out, 1; out_WVALID, out, 1; in_WREADY, in, 1.

Function
REQ-010 AW-side FSM SHALL have states IDLE and SPLIT.
REQ-011 In IDLE, out_REQ_READY SHALL be 1; a request handshake with in_REQ_LEN≠0 SHALL latch the address (low log2(DATA_WIDTH/8) bits forced to 0) and length, then enter SPLIT next cycle.
REQ-012 A request with in_REQ_LEN=0 SHALL be accepted and discarded; the FSM remains in IDLE and issues no burst.
REQ-013 In SPLIT, burst beats SHALL equal min(remaining, MAX_BURST, beats to the next 4 KB boundary); out_AWLEN = beats−1.
REQ-014 out_AWVALID SHALL be 1 in SPLIT only while the length queue is not full; AWADDR/AWLEN SHALL remain stable until handshake.
REQ-015 On AW handshake: push beats into the length queue, advance the address by beats×DATA_WIDTH/8, decrement remaining; if remaining becomes 0, return to IDLE the next cycle.
REQ-016 out_REQ_READY SHALL be 0 in SPLIT; a new request is accepted no earlier than the cycle after the last AW handshake.
REQ-017 W side SHALL pass data combinationally: out_WDATA/out_WSTRB = user inputs; out_WVALID = in_USR_WVALID & queue non-empty; out_USR_WREADY = in_WREADY & queue non-empty.
REQ-018 A beat counter SHALL count W handshakes in the head burst; out_WLAST = queue non-empty & (count == head−1).
REQ-019 On the WLAST handshake, pop the queue and clear the counter in the same cycle.
REQ-020 Simultaneous push and pop of the length queue SHALL both take effect; occupancy is unchanged.
REQ-021 W beats SHALL never be presented before their burst's AW handshake has occurred.
REQ-022 The counter width SHALL cover 256 beats; the 32-bit remaining count SHALL not wrap (decrement bounded by remaining).

Reset
REQ-023 With reset_n=0 at a clk edge: FSM→IDLE, remaining→0, beat counter→0, queue emptied.
REQ-024 Immediately after reset: out_REQ_READY=1, out_AWVALID=0, out_WVALID=0, out_USR_WREADY=0, out_WLAST=0.
REQ-025 Reset mid-burst SHALL abandon all partial bursts; no stale length survives.

Structure
REQ-026 The 4 KB boundary constant, AXI max-length constant (256), and the log2 function SHALL live in a shared package.
REQ-027 The length queue SHALL be an instance of weight_s_loader_wq_weight_s_sum_mmap_m_axi_fifo (DATA_WIDTH 9, DEPTH LEN_FIFO_DEPTH); no other sub-module.

Verification
REQ-028 DATA_WIDTH=32, MAX_BURST=16, request addr 0x0FF0 len 20 -> AW (0x0FF0, AWLEN 3) then (0x1000, AWLEN 15); WLAST on beats 4 and 20.
REQ-029 Request addr 0x0000 len 40 -> AW (0x000,15),(0x040,15),(0x080,7); 40 W beats with WLAST at beats 16, 32, 40.
REQ-030 Request len 0 -> no AWVALID for 10 cycles; out_REQ_READY stays 1.
REQ-031 Hold in_WREADY=0, LEN_FIFO_DEPTH=8, request len 160 -> exactly 8 AW handshakes, then AWVALID=0 until one WLAST pops the queue.
REQ-032 Assert reset_n=0 after AW 2 of 3 and beat 5 -> next cycle: out_AWVALID=0, out_WVALID=0, out_REQ_READY=1; a fresh request len 4 yields AWLEN 3 with WLAST on beat 4.
REQ-033 Random in_AWREADY/in_WREADY/in_USR_WVALID backpressure over 1000 requests -> total W beats equal sum of in_REQ_LEN, no burst crosses 4 KB, every AWLEN+1 matches its WLAST spacing.
